// File: rtl/pipeline_hazard_unit_if.sv
// Decode-side hazard bundle: decode instruction fields in; forward selects, stall and stall count out.
// Outputs are combinational from the unit (zero latency); stall is the only backpressure onto decode.
interface pipeline_hazard_unit_if #(
  parameter int RBITS = 5,
  parameter int FW    = 2,
  parameter int CBITS = 16
);
  logic             id_valid;
  logic [RBITS-1:0] id_rs;
  logic [RBITS-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wr;
  logic [RBITS-1:0] id_wr_reg;
  logic             id_load;
  logic             flush;
  logic             stall;
  logic [FW-1:0]    fwd_a;
  logic [FW-1:0]    fwd_b;
  logic [CBITS-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_wr_reg, id_load, flush,
    input  stall, fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_wr_reg, id_load, flush,
    output stall, fwd_a, fwd_b, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller: scoreboard of in-flight writes drives forward selects and load-use stall.
// Zero-latency combinational outputs; stall holds decode and injects a bubble into stage 1.
module pipeline_hazard_unit #(
  parameter int NSTAGES  = 3,
  parameter int LOAD_LAT = 2,
  parameter int RBITS    = 5,
  parameter int FW       = 2,
  parameter int CBITS    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_unit_if.slave  hz
);

  if (LOAD_LAT < 1 || LOAD_LAT > NSTAGES) begin : g_bad_load_lat
    $error("pipeline_hazard_unit: LOAD_LAT must be within 1..NSTAGES");
  end
  if ((1 << FW) <= NSTAGES) begin : g_bad_fw
    $error("pipeline_hazard_unit: FW too narrow to encode 0..NSTAGES");
  end

  typedef struct packed {
    logic             v;
    logic             wr;
    logic [RBITS-1:0] rgn;
    logic             load;
  } entry_t;

  entry_t           ent [1:NSTAGES];
  logic [CBITS-1:0] cnt;
  logic [FW-1:0]    sel_a, sel_b;
  logic             ld_a, ld_b;
  logic             lu_a, lu_b;
  logic             stall_int;
  logic             issue;

  // Walk oldest to youngest so the youngest matching writer is the one left standing.
  always_comb begin
    sel_a = '0;
    ld_a  = 1'b0;
    sel_b = '0;
    ld_b  = 1'b0;
    for (int k = NSTAGES; k >= 1; k--) begin
      if (hz.id_use_rs && hz.id_rs != '0 && ent[k].v && ent[k].wr && ent[k].rgn == hz.id_rs) begin
        sel_a = FW'(k);
        ld_a  = ent[k].load;
      end
      if (hz.id_use_rt && hz.id_rt != '0 && ent[k].v && ent[k].wr && ent[k].rgn == hz.id_rt) begin
        sel_b = FW'(k);
        ld_b  = ent[k].load;
      end
    end
  end

  // Load data is not ready before LOAD_LAT; sel is nonzero whenever ld_* is set.
  assign lu_a      = ld_a && (sel_a < FW'(LOAD_LAT));
  assign lu_b      = ld_b && (sel_b < FW'(LOAD_LAT));
  assign stall_int = hz.id_valid && !hz.flush && (lu_a || lu_b);
  assign issue     = hz.id_valid && !stall_int && !hz.flush;

  assign hz.stall        = stall_int;
  assign hz.fwd_a        = lu_a ? '0 : sel_a;
  assign hz.fwd_b        = lu_b ? '0 : sel_b;
  assign hz.stall_cycles = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= NSTAGES; k++) begin
        ent[k] <= '0;
      end
      cnt <= '0;
    end else begin
      ent[1] <= issue ? entry_t'{v: 1'b1, wr: hz.id_wr, rgn: hz.id_wr_reg, load: hz.id_load} : '0;
      for (int k = 2; k <= NSTAGES; k++) begin
        ent[k] <= ent[k-1];
      end
      if (stall_int && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed vector table, random stream against a reference scoreboard,
// and counter saturation on a narrow-counter instance.
module tb_pipeline_hazard_unit;
  localparam int NST = 3;
  localparam int LL  = 2;
  localparam int SCB = 4;

  logic clk = 1'b0;
  logic reset;
  logic sat_reset;
  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.RBITS(5), .FW(2), .CBITS(16))  hz ();
  pipeline_hazard_unit_if #(.RBITS(5), .FW(2), .CBITS(SCB)) sz ();

  pipeline_hazard_unit #(.NSTAGES(NST), .LOAD_LAT(LL), .RBITS(5), .FW(2), .CBITS(16)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );
  pipeline_hazard_unit #(.NSTAGES(NST), .LOAD_LAT(LL), .RBITS(5), .FW(2), .CBITS(SCB)) u_sat (
    .clk(clk), .reset(sat_reset), .hz(sz)
  );

  typedef struct {
    logic       vld;
    logic [4:0] rs, rt;
    logic       urs, urt, wr;
    logic [4:0] wreg;
    logic       ld, fl;
  } ins_t;

  typedef struct {
    string       tag;
    ins_t        i;
    logic        st;
    logic [1:0]  fa, fb;
    logic        cc;
    logic [15:0] cnt;
  } vec_t;

  typedef struct packed {
    logic       v, wr, ld;
    logic [4:0] r;
  } ment_t;

  int    n_chk = 0;
  int    n_fail = 0;
  vec_t  tbl[$];
  vec_t  expq[$];
  ment_t m [1:NST];
  logic [15:0] mcnt;

  function automatic ins_t mk(input logic vld, input int rs, input int rt, input logic urs,
                              input logic urt, input logic wr, input int wreg, input logic ld,
                              input logic fl);
    ins_t x;
    x.vld = vld; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt;
    x.wr = wr; x.wreg = 5'(wreg); x.ld = ld; x.fl = fl;
    return x;
  endfunction

  function automatic vec_t V(input string tag, input ins_t i, input logic st, input int fa,
                             input int fb, input logic cc, input int cnt);
    vec_t v;
    v.tag = tag; v.i = i; v.st = st; v.fa = 2'(fa); v.fb = 2'(fb); v.cc = cc; v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: scan from youngest forward, stop at first hit.
  function automatic void pick(input logic u, input logic [4:0] r, output int k, output logic ld);
    k = 0;
    ld = 1'b0;
    if (u && r != 5'd0) begin
      for (int j = 1; j <= NST; j++) begin
        if (k == 0 && m[j].v && m[j].wr && m[j].r == r) begin
          k = j;
          ld = m[j].ld;
        end
      end
    end
  endfunction

  function automatic void model_eval(input ins_t i, output logic st, output logic [1:0] fa,
                                     output logic [1:0] fb);
    int ka, kb;
    logic la, lb, ua, ub;
    pick(i.urs, i.rs, ka, la);
    pick(i.urt, i.rt, kb, lb);
    ua = (ka != 0) && la && (ka < LL);
    ub = (kb != 0) && lb && (kb < LL);
    fa = (ka != 0 && !ua) ? 2'(ka) : 2'd0;
    fb = (kb != 0 && !ub) ? 2'(kb) : 2'd0;
    st = i.vld && !i.fl && (ua || ub);
  endfunction

  function automatic void model_step(input ins_t i, input logic rst);
    logic st;
    logic [1:0] fa, fb;
    model_eval(i, st, fa, fb);
    if (rst) begin
      for (int k = 1; k <= NST; k++) m[k] = '0;
      mcnt = 16'd0;
    end else begin
      if (st && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      for (int k = NST; k >= 2; k--) m[k] = m[k-1];
      if (i.vld && !st && !i.fl) m[1] = '{v: 1'b1, wr: i.wr, ld: i.ld, r: i.wreg};
      else m[1] = '0;
    end
  endfunction

  task automatic drive(input ins_t i);
    hz.id_valid = i.vld; hz.id_rs = i.rs; hz.id_rt = i.rt; hz.id_use_rs = i.urs;
    hz.id_use_rt = i.urt; hz.id_wr = i.wr; hz.id_wr_reg = i.wreg; hz.id_load = i.ld;
    hz.flush = i.fl;
  endtask

  task automatic cycle(input vec_t v, input logic rst);
    vec_t e;
    drive(v.i);
    reset = rst;
    expq.push_back(v);
    @(negedge clk);
    e = expq.pop_front();
    chk({e.tag, ".stall"}, 32'(hz.stall), 32'(e.st));
    chk({e.tag, ".fwd_a"}, 32'(hz.fwd_a), 32'(e.fa));
    chk({e.tag, ".fwd_b"}, 32'(hz.fwd_b), 32'(e.fb));
    if (e.cc) chk({e.tag, ".stall_cycles"}, 32'(hz.stall_cycles), 32'(e.cnt));
    model_step(v.i, rst);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nop, ri;
    logic st;
    logic [1:0] fa, fb;
    logic rst;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl.push_back(V("reset_state", mk(1, 3, 3, 1, 1, 0, 0, 0, 0), 0, 0, 0, 1, 0));
    tbl.push_back(V("t1_add3",  mk(1, 1, 2, 1, 1, 1, 3, 0, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("t1_sub_c1", mk(1, 3, 1, 1, 1, 1, 6, 0, 0), 0, 1, 0, 0, 0));
    tbl.push_back(V("t1_sub_c2", mk(1, 3, 1, 1, 1, 1, 6, 0, 0), 0, 2, 0, 0, 0));
    tbl.push_back(V("t1_sub_c3", mk(1, 3, 1, 1, 1, 1, 6, 0, 0), 0, 3, 0, 0, 0));
    tbl.push_back(V("t1_sub_c4", mk(1, 3, 1, 1, 1, 1, 6, 0, 0), 0, 0, 0, 1, 0));
    repeat (3) tbl.push_back(V("drain", nop, 0, 0, 0, 0, 0));
    tbl.push_back(V("t2_lw4",   mk(1, 1, 0, 1, 0, 1, 4, 1, 0), 0, 0, 0, 1, 0));
    tbl.push_back(V("t2_use_stall", mk(1, 4, 4, 1, 1, 1, 5, 0, 0), 1, 0, 0, 1, 0));
    tbl.push_back(V("t2_use_fwd",   mk(1, 4, 4, 1, 1, 1, 5, 0, 0), 0, 2, 2, 1, 1));
    repeat (3) tbl.push_back(V("drain", nop, 0, 0, 0, 1, 1));
    tbl.push_back(V("t3_add2",  mk(1, 1, 1, 1, 1, 1, 2, 0, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("t3_ori2",  mk(1, 1, 0, 1, 0, 1, 2, 0, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("t3_youngest", mk(1, 2, 2, 1, 1, 1, 7, 0, 0), 0, 1, 1, 0, 0));
    tbl.push_back(V("t3_wr0",   mk(1, 1, 1, 1, 1, 1, 0, 0, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("t3_rd0",   mk(1, 0, 0, 1, 1, 1, 9, 0, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("t3_lw0",   mk(1, 5, 0, 1, 0, 1, 0, 1, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("t3_rd0_ld", mk(1, 0, 0, 1, 1, 1, 9, 0, 0), 0, 0, 0, 1, 1));
    tbl.push_back(V("t3_nouse", mk(1, 9, 9, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    repeat (3) tbl.push_back(V("drain", nop, 0, 0, 0, 0, 0));
    tbl.push_back(V("t4_lw4",   mk(1, 1, 0, 1, 0, 1, 4, 1, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("t4_flush", mk(1, 4, 4, 1, 0, 1, 8, 0, 1), 0, 0, 0, 1, 1));
    tbl.push_back(V("t4_after", mk(1, 4, 8, 1, 1, 1, 10, 0, 0), 0, 2, 0, 1, 1));
    tbl.push_back(V("t4_flush_fwd", mk(1, 10, 0, 1, 0, 0, 0, 0, 1), 0, 1, 0, 0, 0));
    tbl.push_back(V("t4_flushed_gone", mk(1, 10, 0, 1, 0, 0, 0, 0, 0), 0, 2, 0, 0, 0));
    repeat (3) tbl.push_back(V("drain", nop, 0, 0, 0, 0, 0));
    tbl.push_back(V("ld3_lw11", mk(1, 0, 0, 0, 0, 1, 11, 1, 0), 0, 0, 0, 0, 0));
    repeat (2) tbl.push_back(V("ld3_gap", nop, 0, 0, 0, 0, 0));
    tbl.push_back(V("ld3_fwd3", mk(1, 11, 11, 1, 1, 0, 0, 0, 0), 0, 3, 3, 0, 0));
    tbl.push_back(V("ld3_regfile", mk(1, 11, 11, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("mix_add13", mk(1, 0, 0, 0, 0, 1, 13, 0, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("mix_lw12",  mk(1, 0, 0, 0, 0, 1, 12, 1, 0), 0, 0, 0, 0, 0));
    tbl.push_back(V("mix_stall", mk(1, 13, 12, 1, 1, 1, 14, 0, 0), 1, 2, 0, 1, 1));
    tbl.push_back(V("mix_fwd",   mk(1, 13, 12, 1, 1, 1, 14, 0, 0), 0, 3, 2, 1, 2));

    reset = 1'b1;
    sat_reset = 1'b1;
    drive(nop);
    sz.id_valid = 1'b0; sz.id_rs = 5'd0; sz.id_rt = 5'd0; sz.id_use_rs = 1'b0; sz.id_use_rt = 1'b0;
    sz.id_wr = 1'b0; sz.id_wr_reg = 5'd0; sz.id_load = 1'b0; sz.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_step(nop, 1'b1);

    foreach (tbl[n]) cycle(tbl[n], 1'b0);

    // Random stream with occasional flush and reset, small register range to force collisions.
    for (int n = 0; n < 2000; n++) begin
      ri = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      rst = (n == 0) || ($urandom_range(0, 49) == 0);
      model_eval(ri, st, fa, fb);
      cycle(V("rand", ri, st, fa, fb, 1, mcnt), rst);
    end
    reset = 1'b0;

    // Self-dependent load alternates stall/issue, driving the narrow counter into saturation.
    sz.id_valid = 1'b1; sz.id_rs = 5'd4; sz.id_use_rs = 1'b1; sz.id_wr = 1'b1;
    sz.id_wr_reg = 5'd4; sz.id_load = 1'b1;
    sat_reset = 1'b0;
    for (int j = 0; j < 44; j++) begin
      @(negedge clk);
      chk("sat.stall", 32'(sz.stall), 32'(j % 2));
      chk("sat.fwd_a", 32'(sz.fwd_a), (j % 2 == 1 || j == 0) ? 32'd0 : 32'd2);
      chk("sat.stall_cycles", 32'(sz.stall_cycles), (j / 2 > 15) ? 32'd15 : 32'(j / 2));
      if (j == 43) sat_reset = 1'b1;
      @(posedge clk);
      #1;
    end
    sat_reset = 1'b0;
    @(negedge clk);
    chk("sat_reset.stall", 32'(sz.stall), 32'd0);
    chk("sat_reset.fwd_a", 32'(sz.fwd_a), 32'd0);
    chk("sat_reset.fwd_b", 32'(sz.fwd_b), 32'd0);
    chk("sat_reset.stall_cycles", 32'(sz.stall_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
